// File: rtl/tl_a_channel_arbiter.sv
// 2:1 TileLink-UH A-channel arbiter with round-robin grant and Put-burst lock.
// D responses are steered back to the requester by the top source bit.
module tl_a_channel_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int SRC_W    = 4,
    parameter int SIZE_W   = 4,
    parameter int MAX_SIZE = 6
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                a0_valid,
    output logic                a0_ready,
    input  logic [2:0]          a0_opcode,
    input  logic [2:0]          a0_param,
    input  logic [SIZE_W-1:0]   a0_size,
    input  logic [SRC_W-1:0]    a0_source,
    input  logic [ADDR_W-1:0]   a0_address,
    input  logic [DATA_W/8-1:0] a0_mask,
    input  logic [DATA_W-1:0]   a0_data,

    input  logic                a1_valid,
    output logic                a1_ready,
    input  logic [2:0]          a1_opcode,
    input  logic [2:0]          a1_param,
    input  logic [SIZE_W-1:0]   a1_size,
    input  logic [SRC_W-1:0]    a1_source,
    input  logic [ADDR_W-1:0]   a1_address,
    input  logic [DATA_W/8-1:0] a1_mask,
    input  logic [DATA_W-1:0]   a1_data,

    output logic                ao_valid,
    input  logic                ao_ready,
    output logic [2:0]          ao_opcode,
    output logic [2:0]          ao_param,
    output logic [SIZE_W-1:0]   ao_size,
    output logic [SRC_W:0]      ao_source,
    output logic [ADDR_W-1:0]   ao_address,
    output logic [DATA_W/8-1:0] ao_mask,
    output logic [DATA_W-1:0]   ao_data,

    input  logic                d_valid,
    output logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [SIZE_W-1:0]   d_size,
    input  logic [SRC_W:0]      d_source,
    input  logic [DATA_W-1:0]   d_data,
    input  logic                d_denied,
    input  logic                d_corrupt,

    output logic                d0_valid,
    input  logic                d0_ready,
    output logic [2:0]          d0_opcode,
    output logic [1:0]          d0_param,
    output logic [SIZE_W-1:0]   d0_size,
    output logic [SRC_W-1:0]    d0_source,
    output logic [DATA_W-1:0]   d0_data,
    output logic                d0_denied,
    output logic                d0_corrupt,

    output logic                d1_valid,
    input  logic                d1_ready,
    output logic [2:0]          d1_opcode,
    output logic [1:0]          d1_param,
    output logic [SIZE_W-1:0]   d1_size,
    output logic [SRC_W-1:0]    d1_source,
    output logic [DATA_W-1:0]   d1_data,
    output logic                d1_denied,
    output logic                d1_corrupt
);

    localparam int CNT_W = MAX_SIZE - 2;
    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             sel;
    logic             sel_valid;
    logic             fire;
    logic             multi;
    logic [CNT_W-1:0] first_m1;

    // Grant is only free to move in IDLE; HOLD and BURST keep the latched owner.
    always_comb begin
        if (state_q == IDLE) begin
            sel = rr_q ? a1_valid : (~a0_valid & a1_valid);
        end else begin
            sel = grant_q;
        end
    end

    assign sel_valid  = sel ? a1_valid : a0_valid;
    assign ao_valid   = ~reset & sel_valid;
    assign a0_ready   = ~reset & ~sel & ao_ready;
    assign a1_ready   = ~reset &  sel & ao_ready;

    assign ao_opcode  = sel ? a1_opcode  : a0_opcode;
    assign ao_param   = sel ? a1_param   : a0_param;
    assign ao_size    = sel ? a1_size    : a0_size;
    assign ao_source  = {sel, (sel ? a1_source : a0_source)};
    assign ao_address = sel ? a1_address : a0_address;
    assign ao_mask    = sel ? a1_mask    : a0_mask;
    assign ao_data    = sel ? a1_data    : a0_data;

    assign fire  = ao_valid & ao_ready;
    assign multi = ((ao_opcode == OP_PUT_FULL) || (ao_opcode == OP_PUT_PART))
                   && (ao_size > SIZE_W'(3));
    assign first_m1 = (CNT_W'(1) << (ao_size - SIZE_W'(3))) - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HOLD: begin
                if (fire) begin
                    rr_d    = ~sel;
                    grant_d = sel;
                    if (multi) begin
                        cnt_d   = first_m1;
                        state_d = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((state_q == IDLE) && ao_valid) begin
                    grant_d = sel;
                    state_d = HOLD;
                end else if ((state_q == HOLD) && !sel_valid) begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (fire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            grant_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response routing is per beat, so no D-side state is needed.
    assign d0_valid   = d_valid & ~d_source[SRC_W];
    assign d1_valid   = d_valid &  d_source[SRC_W];
    assign d_ready    = d_source[SRC_W] ? d1_ready : d0_ready;

    assign d0_opcode  = d_opcode;
    assign d0_param   = d_param;
    assign d0_size    = d_size;
    assign d0_source  = d_source[SRC_W-1:0];
    assign d0_data    = d_data;
    assign d0_denied  = d_denied;
    assign d0_corrupt = d_corrupt;

    assign d1_opcode  = d_opcode;
    assign d1_param   = d_param;
    assign d1_size    = d_size;
    assign d1_source  = d_source[SRC_W-1:0];
    assign d1_data    = d_data;
    assign d1_denied  = d_denied;
    assign d1_corrupt = d_corrupt;

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Randomized bench for tl_a_channel_arbiter against an owner/beats-left model.
// Requesters hold each offer until accepted; resets are injected mid-traffic.
module tb_tl_a_channel_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int SRC_W  = 4;
    localparam int SIZE_W = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic                v    [2];
    logic                rdy  [2];
    logic [2:0]          op   [2];
    logic [2:0]          prm  [2];
    logic [SIZE_W-1:0]   sz   [2];
    logic [SRC_W-1:0]    src  [2];
    logic [ADDR_W-1:0]   adr  [2];
    logic [DATA_W/8-1:0] msk  [2];
    logic [DATA_W-1:0]   dat  [2];

    logic                ao_valid, ao_ready;
    logic [2:0]          ao_opcode, ao_param;
    logic [SIZE_W-1:0]   ao_size;
    logic [SRC_W:0]      ao_source;
    logic [ADDR_W-1:0]   ao_address;
    logic [DATA_W/8-1:0] ao_mask;
    logic [DATA_W-1:0]   ao_data;

    logic                d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [SIZE_W-1:0]   d_size;
    logic [SRC_W:0]      d_source;
    logic [DATA_W-1:0]   d_data;

    logic                dv   [2];
    logic                dr   [2];
    logic [2:0]          dop  [2];
    logic [1:0]          dprm [2];
    logic [SIZE_W-1:0]   dsz  [2];
    logic [SRC_W-1:0]    dsrc [2];
    logic [DATA_W-1:0]   ddat [2];
    logic                dden [2];
    logic                dcor [2];

    tl_a_channel_arbiter dut (
        .clock(clock), .reset(reset),
        .a0_valid(v[0]), .a0_ready(rdy[0]), .a0_opcode(op[0]),
        .a0_param(prm[0]), .a0_size(sz[0]), .a0_source(src[0]),
        .a0_address(adr[0]), .a0_mask(msk[0]), .a0_data(dat[0]),
        .a1_valid(v[1]), .a1_ready(rdy[1]), .a1_opcode(op[1]),
        .a1_param(prm[1]), .a1_size(sz[1]), .a1_source(src[1]),
        .a1_address(adr[1]), .a1_mask(msk[1]), .a1_data(dat[1]),
        .ao_valid(ao_valid), .ao_ready(ao_ready), .ao_opcode(ao_opcode),
        .ao_param(ao_param), .ao_size(ao_size), .ao_source(ao_source),
        .ao_address(ao_address), .ao_mask(ao_mask), .ao_data(ao_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_data(d_data), .d_denied(d_denied), .d_corrupt(d_corrupt),
        .d0_valid(dv[0]), .d0_ready(dr[0]), .d0_opcode(dop[0]),
        .d0_param(dprm[0]), .d0_size(dsz[0]), .d0_source(dsrc[0]),
        .d0_data(ddat[0]), .d0_denied(dden[0]), .d0_corrupt(dcor[0]),
        .d1_valid(dv[1]), .d1_ready(dr[1]), .d1_opcode(dop[1]),
        .d1_param(dprm[1]), .d1_size(dsz[1]), .d1_source(dsrc[1]),
        .d1_data(ddat[1]), .d1_denied(dden[1]), .d1_corrupt(dcor[1])
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input int o, input int s);
        return (o <= 1 && s > 3) ? (1 << (s - 3)) : 1;
    endfunction

    // Requester drivers
    bit act  [2];
    bit held [2];
    int beat [2];
    int nb   [2];

    // Reference model: who owns the port, and burst beats still owed
    int owner;
    int left;
    int rr;

    // Last cycle's outcome, applied at the next negedge
    int g;
    bit e_av;
    bit fired;

    task automatic new_beat(input int r);
        dat[r] = {$urandom, $urandom};
        msk[r] = 8'($urandom);
    endtask

    task automatic new_txn(input int r);
        case ($urandom % 3)
            0: op[r] = 3'd0;
            1: op[r] = 3'd1;
            default: op[r] = 3'd4;
        endcase
        sz[r]   = SIZE_W'($urandom % 7);
        prm[r]  = 3'($urandom);
        src[r]  = SRC_W'($urandom);
        adr[r]  = $urandom;
        nb[r]   = beats_of(int'(op[r]), int'(sz[r]));
        beat[r] = 0;
        act[r]  = 1'b1;
        held[r] = 1'b0;
        new_beat(r);
    endtask

    task automatic drive_d();
        d_valid   = 1'($urandom);
        d_opcode  = 3'($urandom);
        d_param   = 2'($urandom);
        d_size    = SIZE_W'($urandom);
        d_source  = (SRC_W + 1)'($urandom);
        d_data    = {$urandom, $urandom};
        d_denied  = 1'($urandom);
        d_corrupt = 1'($urandom);
        dr[0]     = 1'($urandom);
        dr[1]     = 1'($urandom);
    endtask

    task automatic check_d();
        chk("d0_valid", dv[0], d_valid & ~d_source[SRC_W]);
        chk("d1_valid", dv[1], d_valid & d_source[SRC_W]);
        chk("d_ready", d_ready, d_source[SRC_W] ? dr[1] : dr[0]);
        chk("d0_src", dsrc[0], d_source[SRC_W-1:0]);
        chk("d1_fields", {dop[1], dprm[1], dsz[1], dsrc[1], ddat[1], dden[1], dcor[1]},
            {d_opcode, d_param, d_size, d_source[SRC_W-1:0], d_data, d_denied, d_corrupt});
    endtask

    // Protocol watchdogs on the requester side
    logic pend [2];
    always @(posedge clock) begin
        for (int r = 0; r < 2; r++) begin
            if (!reset && v[r]) begin
                assert (sz[r] <= SIZE_W'(6))
                    else $error("illegal size on requester %0d", r);
            end
            if (!reset && pend[r]) begin
                assert (v[r]) else $error("request withdrawn on %0d", r);
            end
            pend[r] <= v[r] & ~rdy[r] & ~reset;
        end
    end

    initial begin
        int mode;
        reset    = 1'b1;
        ao_ready = 1'b1;
        owner    = -1;
        left     = 0;
        rr       = 0;
        fired    = 1'b0;
        e_av     = 1'b0;
        g        = 0;
        for (int r = 0; r < 2; r++) begin
            new_txn(r);
            v[r]    = 1'b1;
            act[r]  = 1'b0;
            pend[r] = 1'b0;
        end
        drive_d();
        #1;
        chk("rst_ao_valid", ao_valid, 1'b0);
        chk("rst_a0_ready", rdy[0], 1'b0);
        chk("rst_a1_ready", rdy[1], 1'b0);
        check_d();
        for (int r = 0; r < 2; r++) v[r] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc != 0) @(negedge clock);
            mode = (cyc / 250) % 3;

            // Apply last cycle's accepted beat to the model and the driver
            if (left > 0) begin
                if (fired) begin
                    left--;
                    if (left == 0) owner = -1;
                end
            end else if (fired) begin
                rr = 1 - g;
                if (nb[g] > 1) begin
                    owner = g;
                    left  = nb[g] - 1;
                end else begin
                    owner = -1;
                end
            end else if (e_av) begin
                owner = g;
            end
            for (int r = 0; r < 2; r++) begin
                if (fired && g == r) begin
                    beat[r]++;
                    if (beat[r] == nb[r]) act[r] = 1'b0;
                    else new_beat(r);
                    held[r] = 1'b0;
                end else begin
                    held[r] = v[r];
                end
            end
            fired = 1'b0;
            e_av  = 1'b0;

            if (reset) reset = 1'b0;

            if (cyc > 20 && ($urandom % 90) == 0) begin
                reset = 1'b1;
                owner = -1;
                left  = 0;
                rr    = 0;
                for (int r = 0; r < 2; r++) begin
                    act[r]  = 1'b0;
                    held[r] = 1'b0;
                    v[r]    = 1'b1;
                end
                ao_ready = 1'b1;
                drive_d();
                #1;
                chk("rst_ao_valid", ao_valid, 1'b0);
                chk("rst_a0_ready", rdy[0], 1'b0);
                chk("rst_a1_ready", rdy[1], 1'b0);
                check_d();
                for (int r = 0; r < 2; r++) v[r] = 1'b0;
                continue;
            end

            for (int r = 0; r < 2; r++) begin
                if (!act[r] && ($urandom % 3) != 0) new_txn(r);
                v[r] = act[r] && (held[r] || beat[r] == 0 || ($urandom % 4) != 0);
            end
            case (mode)
                0: ao_ready = 1'b1;
                1: ao_ready = cyc[0];
                default: ao_ready = ($urandom % 4) != 0;
            endcase
            drive_d();
            #1;

            if (owner >= 0) g = owner;
            else if (v[rr]) g = rr;
            else if (v[1-rr]) g = 1 - rr;
            else g = 0;
            e_av  = v[g];
            fired = e_av && ao_ready;

            chk("ao_valid", ao_valid, e_av);
            chk("a0_ready", rdy[0], (g == 0) && ao_ready);
            chk("a1_ready", rdy[1], (g == 1) && ao_ready);
            if (e_av) begin
                chk("ao_source", ao_source, {g[0], src[g]});
                chk("ao_hdr", {ao_opcode, ao_param, ao_size}, {op[g], prm[g], sz[g]});
                chk("ao_address", ao_address, adr[g]);
                chk("ao_mask", ao_mask, msk[g]);
                chk("ao_data", ao_data, dat[g]);
            end
            check_d();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
